// File: rtl/xocc_dsa_sched_pkg.sv
// Shared types and helpers for the XOCC DSA scheduler.
package xocc_dsa_sched_pkg;

    // Scheduler FSM states
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ISSUE    = 2'd1,
        ST_WAIT_RSP = 2'd2,
        ST_ERR_WR   = 2'd3
    } sched_state_e;

    // Response word written into the response FIFO when the engine times out
    localparam logic [31:0] ERR_CODE_DEF = 32'hDEAD_0001;

    // Queue-id width for a given queue count (never narrower than one bit)
    function automatic int qw_of(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/xocc_dsa_sched_if.sv
// Command/response handshake between the scheduler and the shared DSA engine.
interface xocc_dsa_sched_if #(
    parameter int CMD_W = 96,
    parameter int RSP_W = 32,
    parameter int QW    = 4
);
    logic             eng_cmd_vld;
    logic             eng_cmd_rdy;
    logic [CMD_W-1:0] eng_cmd_data;
    logic [QW-1:0]    eng_cmd_qid;
    logic             eng_rsp_vld;
    logic             eng_rsp_rdy;
    logic [RSP_W-1:0] eng_rsp_data;
    logic             eng_abort;

    // Scheduler side
    modport master (
        output eng_cmd_vld, eng_cmd_data, eng_cmd_qid, eng_rsp_rdy, eng_abort,
        input  eng_cmd_rdy, eng_rsp_vld, eng_rsp_data
    );

    // Engine side
    modport slave (
        input  eng_cmd_vld, eng_cmd_data, eng_cmd_qid, eng_rsp_rdy, eng_abort,
        output eng_cmd_rdy, eng_rsp_vld, eng_rsp_data
    );
endinterface

// File: rtl/xocc_dsa_sched_arb.sv
// Combinational round-robin arbiter: first requester at or after i_ptr, wrapping.
module xocc_rr_arb #(
    parameter int NUM_Q = 16,
    parameter int QW    = 4
) (
    input  logic [NUM_Q-1:0] i_req,
    input  logic [QW-1:0]    i_ptr,
    output logic [NUM_Q-1:0] o_gnt_oh,
    output logic [QW-1:0]    o_gnt_idx,
    output logic             o_gnt_vld
);

    // Scan NUM_Q positions starting at the pointer; the first hit wins
    always_comb begin
        int         w_pos;
        logic [QW-1:0] w_idx;
        logic       w_found;
        o_gnt_oh  = '0;
        o_gnt_idx = '0;
        w_found   = 1'b0;
        w_pos     = 0;
        w_idx     = '0;
        for (int k = 0; k < NUM_Q; k++) begin
            w_pos = int'(i_ptr) + k;
            if (w_pos >= NUM_Q) w_pos = w_pos - NUM_Q;
            w_idx = QW'(w_pos);
            if (!w_found && i_req[w_idx]) begin
                w_found         = 1'b1;
                o_gnt_idx       = w_idx;
                o_gnt_oh[w_idx] = 1'b1;
            end
        end
        o_gnt_vld = w_found;
    end

endmodule

// File: rtl/xocc_dsa_sched.sv
// Single-engine scheduler: round-robin pops per-DSA command FIFOs into one
// engine, waits for the response and pushes it to the issuing queue's
// response FIFO. A watchdog aborts silent commands and writes an error word.
module xocc_dsa_sched
    import xocc_dsa_sched_pkg::*;
#(
    parameter int               NUM_Q       = 16,
    parameter int               QW          = qw_of(NUM_Q),
    parameter int               CMD_W       = 96,
    parameter int               RSP_W       = 32,
    parameter int               TIMEOUT_CYC = 1024,
    parameter logic [RSP_W-1:0] ERR_CODE    = RSP_W'(ERR_CODE_DEF)
) (
    input  logic                   forever_cpuclk,
    input  logic                   cpurst_b,
    input  logic [NUM_Q-1:0]       q_en,
    input  logic [NUM_Q-1:0]       empty_cmd,
    input  logic [NUM_Q*CMD_W-1:0] dsa_cmd_buffer,
    output logic [NUM_Q-1:0]       rd_en_cmd,
    input  logic [NUM_Q-1:0]       full_rsp,
    output logic [NUM_Q-1:0]       wr_en_rsp,
    output logic [RSP_W-1:0]       dsa_rsp_buffer,
    xocc_dsa_sched_if.master       eng,
    output logic                   sched_busy,
    output logic [NUM_Q-1:0]       timeout_err,
    input  logic                   err_clr
);

    // Watchdog only needs to reach TIMEOUT_CYC-1; the hit cycle is the abort cycle
    localparam int              WD_W   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [WD_W-1:0] WD_LIM = WD_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
    localparam bit              WD_EN  = (TIMEOUT_CYC != 0);

    sched_state_e     r_state;
    sched_state_e     w_state_nxt;
    logic [QW-1:0]    r_cur_qid;
    logic [NUM_Q-1:0] r_cur_oh;
    logic [QW-1:0]    r_ptr;
    logic [WD_W-1:0]  r_wd;
    logic [NUM_Q-1:0] r_timeout_err;

    logic [NUM_Q-1:0] w_req;
    logic [NUM_Q-1:0] w_gnt_oh;
    logic [QW-1:0]    w_gnt_idx;
    logic             w_gnt_vld;
    logic             w_cur_full;
    logic             w_wd_hit;
    logic [CMD_W-1:0] w_cmd_slice;

    logic             w_cmd_vld;
    logic [CMD_W-1:0] w_cmd_data;
    logic [QW-1:0]    w_cmd_qid;
    logic             w_rsp_rdy;
    logic             w_abort;
    logic             w_load_qid;
    logic             w_adv_ptr;
    logic             w_wd_clr;
    logic             w_wd_inc;
    logic [NUM_Q-1:0] w_err_set;

    // Pointer advance wraps at NUM_Q, which need not be a power of two
    function automatic logic [QW-1:0] f_next_q(input logic [QW-1:0] q);
        if (int'(q) == NUM_Q - 1) return '0;
        return q + 1'b1;
    endfunction

    assign w_req       = ~empty_cmd & q_en;
    assign w_cur_full  = full_rsp[r_cur_qid];
    assign w_cmd_slice = dsa_cmd_buffer[int'(r_cur_qid)*CMD_W +: CMD_W];
    assign w_wd_hit    = WD_EN && (r_wd == WD_LIM);

    xocc_rr_arb #(
        .NUM_Q (NUM_Q),
        .QW    (QW)
    ) u_arb (
        .i_req     (w_req),
        .i_ptr     (r_ptr),
        .o_gnt_oh  (w_gnt_oh),
        .o_gnt_idx (w_gnt_idx),
        .o_gnt_vld (w_gnt_vld)
    );

    // Next-state and all handshake/FIFO strobes, decoded from the current state
    always_comb begin
        w_state_nxt    = r_state;
        rd_en_cmd      = '0;
        wr_en_rsp      = '0;
        dsa_rsp_buffer = '0;
        w_cmd_vld      = 1'b0;
        w_cmd_data     = '0;
        w_cmd_qid      = '0;
        w_rsp_rdy      = 1'b0;
        w_abort        = 1'b0;
        w_load_qid     = 1'b0;
        w_adv_ptr      = 1'b0;
        w_wd_clr       = 1'b0;
        w_wd_inc       = 1'b0;
        w_err_set      = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_gnt_vld) begin
                    w_load_qid  = 1'b1;
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // Only this block pops, so the head stays valid even if q_en drops
                w_cmd_vld  = 1'b1;
                w_cmd_data = w_cmd_slice;
                w_cmd_qid  = r_cur_qid;
                if (eng.eng_cmd_rdy) begin
                    rd_en_cmd   = r_cur_oh;
                    w_wd_clr    = 1'b1;
                    w_state_nxt = ST_WAIT_RSP;
                end
            end
            ST_WAIT_RSP: begin
                // A full response FIFO stalls the engine and freezes the watchdog
                w_rsp_rdy = ~w_cur_full;
                if (!w_cur_full) begin
                    if (eng.eng_rsp_vld) begin
                        wr_en_rsp      = r_cur_oh;
                        dsa_rsp_buffer = eng.eng_rsp_data;
                        w_adv_ptr      = 1'b1;
                        w_state_nxt    = ST_IDLE;
                    end else if (w_wd_hit) begin
                        w_abort     = 1'b1;
                        w_err_set   = r_cur_oh;
                        w_state_nxt = ST_ERR_WR;
                    end else begin
                        w_wd_inc = 1'b1;
                    end
                end
            end
            ST_ERR_WR: begin
                if (!w_cur_full) begin
                    wr_en_rsp      = r_cur_oh;
                    dsa_rsp_buffer = ERR_CODE;
                    w_adv_ptr      = 1'b1;
                    w_state_nxt    = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) r_state <= ST_IDLE;
        else           r_state <= w_state_nxt;
    end

    // Granted queue, round-robin pointer and watchdog counter
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            r_cur_qid <= '0;
            r_cur_oh  <= '0;
            r_ptr     <= '0;
            r_wd      <= '0;
        end else begin
            if (w_load_qid) begin
                r_cur_qid <= w_gnt_idx;
                r_cur_oh  <= w_gnt_oh;
            end
            if (w_adv_ptr) r_ptr <= f_next_q(r_cur_qid);
            if (w_wd_clr)      r_wd <= '0;
            else if (w_wd_inc) r_wd <= r_wd + 1'b1;
        end
    end

    // Sticky per-queue timeout flags; a new timeout beats a coincident clear
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) r_timeout_err <= '0;
        else           r_timeout_err <= (r_timeout_err & ~{NUM_Q{err_clr}}) | w_err_set;
    end

    assign eng.eng_cmd_vld  = w_cmd_vld;
    assign eng.eng_cmd_data = w_cmd_data;
    assign eng.eng_cmd_qid  = w_cmd_qid;
    assign eng.eng_rsp_rdy  = w_rsp_rdy;
    assign eng.eng_abort    = w_abort;
    assign sched_busy       = (r_state != ST_IDLE);
    assign timeout_err      = r_timeout_err;

endmodule
